// File: rtl/plotter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | plotter_pkg : shared state encoding and default geometry for the plotter |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package plotter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POINTS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SWEEP  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int DEF_XRES = 320;
  localparam int DEF_YRES = 240;
  localparam int XHALF    = DEF_XRES / 2;
  localparam int YHALF    = DEF_YRES / 2;
  localparam int VX_W     = $clog2(DEF_XRES);
  localparam int VY_W     = $clog2(DEF_YRES);

endpackage
`default_nettype wire

// File: rtl/plot_xform.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | plot_xform : registered centred-(x,y) to VGA pixel transform with clip.  |
// |              PLOT_CLAMP_EN clamps off-screen y instead of suppressing it.|
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module plot_xform
  import plotter_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int XRES    = DEF_XRES,
  parameter int YRES    = DEF_YRES,
  parameter int X_OFF   = XHALF,
  parameter int Y_OFF   = YHALF,
  parameter int VX_BITS = VX_W,
  parameter int VY_BITS = VY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic [VX_BITS-1:0] vga_x,
  output logic [VY_BITS-1:0] vga_y,
  output logic               plot
);

  // One extra bit keeps the offset arithmetic free of overflow.
  localparam int IW = COORD_W + 1;
  localparam logic signed [IW-1:0] XO = IW'(X_OFF);
  localparam logic signed [IW-1:0] YT = IW'(Y_OFF - 1);
  localparam logic signed [IW-1:0] XL = IW'(XRES);
  localparam logic signed [IW-1:0] YL = IW'(YRES);

  logic signed [IW-1:0] sx, sy, vx, vy;
  logic                 x_on, y_above, y_below, pix_ok;
  logic [VY_BITS-1:0]   vy_pix;

  always_comb begin
    sx      = $signed({in_x[COORD_W-1], in_x});
    sy      = $signed({in_y[COORD_W-1], in_y});
    vx      = sx + XO;
    vy      = YT - sy;
    x_on    = !vx[IW-1] && (vx < XL);
    y_above = vy[IW-1];
    y_below = !vy[IW-1] && (vy >= YL);
`ifdef PLOT_CLAMP_EN
    vy_pix  = y_above ? '0 : (y_below ? VY_BITS'(YRES - 1) : vy[VY_BITS-1:0]);
    pix_ok  = x_on;
`else
    vy_pix  = vy[VY_BITS-1:0];
    pix_ok  = x_on && !y_above && !y_below;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot  <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
    end else begin
      plot <= in_valid && pix_ok;
      if (in_valid) begin
        vga_x <= vx[VX_BITS-1:0];
        vga_y <= vy_pix;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/curve_plotter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | curve_plotter : plots training samples, then sweeps x through an external|
// |                 evaluator and plots the fitted curve. Build option:      |
// |                 PLOT_CLAMP_EN (clamp off-screen y rather than drop it).  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module curve_plotter
  import plotter_pkg::*;
#(
  parameter int COORD_W  = 12,
  parameter int XRES     = DEF_XRES,
  parameter int YRES     = DEF_YRES,
  parameter int N_POINTS = 4,
  parameter int XMIN     = -160,
  parameter int XMAX     = 159,
  parameter int EVAL_LAT = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  input  logic [COORD_W-1:0]      pt_x,
  input  logic [COORD_W-1:0]      pt_y,
  input  logic                    sweep_start,
  input  logic                    sweep_last,
  output logic [COORD_W-1:0]      eval_x,
  input  logic [COORD_W-1:0]      eval_y,
  output logic [$clog2(XRES)-1:0] vga_x,
  output logic [$clog2(YRES)-1:0] vga_y,
  output logic                    plot,
  output logic                    sweep_done,
  output logic                    busy
);

  localparam int VXW = $clog2(XRES);
  localparam int VYW = $clog2(YRES);
  localparam int DW  = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  localparam logic [COORD_W-1:0] X_LO    = COORD_W'(XMIN);
  localparam logic [COORD_W-1:0] X_HI    = COORD_W'(XMAX);
  localparam logic [7:0]         PT_LAST = 8'(N_POINTS - 1);
  localparam logic [DW-1:0]      DR_LAST = DW'(EVAL_LAT - 1);

  state_t        state;
  logic [7:0]    pt_cnt;
  logic [DW-1:0] drain_cnt;
  logic          last_flag;
  logic          pt_fire;

  assign pt_fire = pt_valid && pt_ready;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      pt_ready   <= 1'b0;
      sweep_done <= 1'b0;
      eval_x     <= '0;
      pt_cnt     <= '0;
      drain_cnt  <= '0;
      last_flag  <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (state != ST_IDLE && sweep_last)
        last_flag <= 1'b1;
      case (state)
        ST_IDLE: begin
          pt_ready <= 1'b1;
          if (pt_fire) begin
            pt_cnt <= 8'd1;
            if (N_POINTS == 1) begin
              state    <= ST_WAIT;
              pt_ready <= 1'b0;
            end else begin
              state <= ST_POINTS;
            end
          end
        end
        ST_POINTS: begin
          if (pt_fire) begin
            pt_cnt <= pt_cnt + 8'd1;
            if (pt_cnt == PT_LAST) begin
              state    <= ST_WAIT;
              pt_ready <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (sweep_start) begin
            state  <= ST_SWEEP;
            eval_x <= X_LO;
          end
        end
        ST_SWEEP: begin
          if (eval_x == X_HI) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            eval_x <= eval_x + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DR_LAST)
            state <= ST_DONE;
          else
            drain_cnt <= drain_cnt + 1'b1;
        end
        ST_DONE: begin
          sweep_done <= 1'b1;
          if (last_flag) begin
            state     <= ST_IDLE;
            last_flag <= 1'b0;
            pt_ready  <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // x delay line pairs each returning eval_y with the x that produced it.
  logic [COORD_W-1:0] x_dly [EVAL_LAT];
  logic [EVAL_LAT-1:0] v_dly;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      v_dly <= '0;
      for (int i = 0; i < EVAL_LAT; i++)
        x_dly[i] <= '0;
    end else begin
      x_dly[0] <= eval_x;
      v_dly[0] <= (state == ST_SWEEP);
      for (int i = 1; i < EVAL_LAT; i++) begin
        x_dly[i] <= x_dly[i-1];
        v_dly[i] <= v_dly[i-1];
      end
    end
  end

  logic               xf_valid;
  logic [COORD_W-1:0] xf_x, xf_y;

  always_comb begin
    if (pt_fire) begin
      xf_valid = 1'b1;
      xf_x     = pt_x;
      xf_y     = pt_y;
    end else begin
      xf_valid = v_dly[EVAL_LAT-1];
      xf_x     = x_dly[EVAL_LAT-1];
      xf_y     = eval_y;
    end
  end

  plot_xform #(
    .COORD_W (COORD_W),
    .XRES    (XRES),
    .YRES    (YRES),
    .X_OFF   (XRES / 2),
    .Y_OFF   (YRES / 2),
    .VX_BITS (VXW),
    .VY_BITS (VYW)
  ) u_xform (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .in_valid (xf_valid),
    .in_x     (xf_x),
    .in_y     (xf_y),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .plot     (plot)
  );

endmodule
`default_nettype wire

// File: tb/tb_curve_plotter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_curve_plotter : directed bench for curve_plotter, default geometry    |
// |                    plus a short-sweep, long-latency instance.            |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_curve_plotter;

  localparam int CW = 12;
`ifdef PLOT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic          resetn, pt_valid, pt_ready, sweep_start, sweep_last;
  logic          plot, sweep_done, busy;
  logic [CW-1:0] pt_x, pt_y, eval_x, eval_y, ev_d1, ev_d2;
  logic [8:0]    vga_x;
  logic [7:0]    vga_y;

  // stub evaluator: eval_y = eval_x, two cycles late
  always_ff @(posedge clk) begin
    ev_d1 <= eval_x;
    ev_d2 <= ev_d1;
  end
  assign eval_y = ev_d2;

  curve_plotter u_dut (
    .CLOCK_50(clk), .resetn(resetn), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .sweep_start(sweep_start), .sweep_last(sweep_last),
    .eval_x(eval_x), .eval_y(eval_y), .vga_x(vga_x), .vga_y(vga_y),
    .plot(plot), .sweep_done(sweep_done), .busy(busy)
  );

  // short sweep, latency 5, eval_y tied to 0
  logic          resetn6, pt_valid6, pt_ready6, sweep_start6, sweep_last6;
  logic          plot6, sweep_done6, busy6;
  logic [CW-1:0] pt_x6, pt_y6, eval_x6, eval_y6;
  logic [8:0]    vga_x6;
  logic [7:0]    vga_y6;
  assign eval_y6 = '0;

  curve_plotter #(.EVAL_LAT(5), .XMIN(-4), .XMAX(3)) u_dut6 (
    .CLOCK_50(clk), .resetn(resetn6), .pt_valid(pt_valid6), .pt_ready(pt_ready6),
    .pt_x(pt_x6), .pt_y(pt_y6), .sweep_start(sweep_start6), .sweep_last(sweep_last6),
    .eval_x(eval_x6), .eval_y(eval_y6), .vga_x(vga_x6), .vga_y(vga_y6),
    .plot(plot6), .sweep_done(sweep_done6), .busy(busy6)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  localparam int PX [4] = '{0, -160, 159, 10};
  localparam int PY [4] = '{0, 119, -120, 200};
  localparam int EX [4] = '{160, 0, 319, 170};
  localparam int EY [4] = '{119, 0, 239, 0};

  // Called on a negedge with pt_ready high; pulses sweep_start mid-load.
  task automatic send_pts(input bit check_pix);
    for (int i = 0; i < 4; i++) begin
      pt_valid    = 1'b1;
      pt_x        = CW'(PX[i]);
      pt_y        = CW'(PY[i]);
      sweep_start = (i == 1);
      @(negedge clk);
      if (check_pix) begin
        chk($sformatf("pt%0d_plot", i), int'(plot), (i == 3) ? int'(CLAMP) : 1);
        if (plot) begin
          chk($sformatf("pt%0d_vx", i), int'(vga_x), EX[i]);
          chk($sformatf("pt%0d_vy", i), int'(vga_y), EY[i]);
        end
      end
    end
    pt_valid    = 1'b0;
    sweep_start = 1'b0;
  endtask

  // Called on a negedge in WAIT. Observes 340 cycles from SWEEP entry.
  task automatic do_sweep(input bit last, output int n_plot, output int first,
                          output int lastp, output int done_at, output int n_done,
                          output int x_err, output int pix_err);
    int x, ey;
    n_plot = 0; first = -1; lastp = -1; done_at = -1; n_done = 0;
    x_err = 0; pix_err = 0;
    sweep_start = 1'b1;
    sweep_last  = last;
    @(negedge clk);
    sweep_start = 1'b0;
    sweep_last  = 1'b0;
    for (int r = 0; r < 340; r++) begin
      if (r < 320 && $signed(eval_x) != -160 + r) x_err++;
      if (r >= 320 && r < 323 && $signed(eval_x) != 159) x_err++;
      if (plot) begin
        n_plot++;
        if (first < 0) first = r;
        lastp = r;
        x  = r - 163;
        ey = 119 - x;
        if (ey < 0)   ey = 0;
        if (ey > 239) ey = 239;
        if (int'(vga_x) != r - 3 || int'(vga_y) != ey) pix_err++;
      end
      if (sweep_done) begin
        n_done++;
        done_at = r;
      end
      sweep_start = (r == 100);
      @(negedge clk);
    end
    sweep_start = 1'b0;
  endtask

  initial begin
    int np, fp, lp, da, nd, xe, pe, cnt;
    resetn = 1'b0; resetn6 = 1'b0;
    pt_valid = 0; pt_x = '0; pt_y = '0; sweep_start = 0; sweep_last = 0;
    pt_valid6 = 0; pt_x6 = '0; pt_y6 = '0; sweep_start6 = 0; sweep_last6 = 0;
    repeat (3) @(negedge clk);
    chk("rst_pt_ready", int'(pt_ready), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);
    chk("rst_eval_x", int'(eval_x), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    resetn = 1'b1; resetn6 = 1'b1;
    @(negedge clk);
    chk("idle_pt_ready", int'(pt_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // samples, with a stray sweep_start during POINTS
    send_pts(1'b1);
    chk("wait_pt_ready", int'(pt_ready), 0);
    chk("wait_busy", int'(busy), 1);
    cnt = 0;
    repeat (6) begin @(negedge clk); cnt += int'(plot); end
    chk("points_start_ignored_plots", cnt, 0);
    chk("points_start_ignored_eval_x", int'(eval_x), 0);

    // full sweep, stray sweep_start during SWEEP
    do_sweep(1'b0, np, fp, lp, da, nd, xe, pe);
    chk("sw1_nplot", np, CLAMP ? 320 : 240);
    chk("sw1_first", fp, CLAMP ? 3 : 43);
    chk("sw1_last", lp, CLAMP ? 322 : 282);
    chk("sw1_done_at", da, 323);
    chk("sw1_ndone", nd, 1);
    chk("sw1_eval_x_seq", xe, 0);
    chk("sw1_pixels", pe, 0);
    chk("sw1_busy_wait", int'(busy), 1);
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(plot) + int'(sweep_done); end
    chk("sw1_no_extra_sweep", cnt, 0);

    // final sweep: sweep_last with sweep_start
    do_sweep(1'b1, np, fp, lp, da, nd, xe, pe);
    chk("sw2_nplot", np, CLAMP ? 320 : 240);
    chk("sw2_done_at", da, 323);
    chk("sw2_busy_idle", int'(busy), 0);
    chk("sw2_pt_ready", int'(pt_ready), 1);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(plot) + int'(busy); end
    chk("idle_start_ignored", cnt, 0);

    // sweep_last in IDLE must not make the next run final
    sweep_last = 1'b1;
    repeat (5) @(negedge clk);
    sweep_last = 1'b0;
    send_pts(1'b0);
    do_sweep(1'b0, np, fp, lp, da, nd, xe, pe);
    chk("sw3_ndone", nd, 1);
    chk("sw3_back_to_wait", int'(busy), 1);

    // reset 100 cycles into a sweep
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_plot", int'(plot), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_plot", int'(plot), 0);
    chk("async_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_pt_ready", int'(pt_ready), 1);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(plot); end
    chk("post_rst_no_plot", cnt, 0);

    // short sweep, EVAL_LAT=5
    for (int i = 0; i < 4; i++) begin
      pt_valid6 = 1'b1;
      @(negedge clk);
    end
    pt_valid6    = 1'b0;
    sweep_start6 = 1'b1;
    @(negedge clk);
    sweep_start6 = 1'b0;
    np = 0; fp = -1; da = -1; pe = 0;
    for (int r = 0; r < 25; r++) begin
      if (plot6) begin
        np++;
        if (fp < 0) fp = r;
        if (int'(vga_x6) != 150 + r || int'(vga_y6) != 119) pe++;
      end
      if (sweep_done6) da = r;
      @(negedge clk);
    end
    chk("lat5_nplot", np, 8);
    chk("lat5_first", fp, 6);
    chk("lat5_pixels", pe, 0);
    chk("lat5_done_at", da, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
